tflipflop_bank_counter: RTL and testbench

//   WIDTH-bit register built from T flip-flops: per-bit toggle, parallel load, up/down modulo counting.

---
 rtl/tflipflop_bank_counter.sv | 91 +++++++++
 tb/tb_tflipflop_bank_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tflipflop_bank_counter.sv
// rtl/tflipflop_bank_counter.sv - WIDTH-bit T flip-flop bank with toggle, load and up/down modulo counting
// Define TFF_COUNTER_SAT_EN to make the count modes saturate at their bounds instead of wrapping.
module tflipflop_bank_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 2**WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Res,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic [WIDTH-1:0] T,
  input  logic [1:0]       Mode,
  output logic [WIDTH-1:0] Q,
  output logic             Tc
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  // One extra bit so a full-range modulus (2**WIDTH) is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST     = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] din_clamped;
  logic             at_top;
  logic             at_zero;

  assign din_clamped = ({1'b0, Din} >= MOD_EXT) ? TOP : Din;
  // >= rather than == so an out-of-range value left by a toggle still wraps.
  assign at_top      = (Q >= TOP);
  assign at_zero     = (Q == '0);

  always_comb begin
    q_nxt  = Q;
    tc_nxt = 1'b0;
    if (Load) begin
      q_nxt = din_clamped;
    end else if (En) begin
      case (mode_t'(Mode))
        MODE_TOGGLE: q_nxt = Q ^ T;
        MODE_UP: begin
          if (at_top) begin
`ifdef TFF_COUNTER_SAT_EN
            q_nxt = TOP;
`else
            q_nxt = '0;
`endif
            tc_nxt = 1'b1;
          end else begin
            q_nxt = Q + ONE;
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
`ifdef TFF_COUNTER_SAT_EN
            q_nxt = '0;
`else
            q_nxt = TOP;
`endif
            tc_nxt = 1'b1;
          end else begin
            q_nxt = Q - ONE;
          end
        end
        MODE_HOLD: q_nxt = Q;
        default:   q_nxt = Q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Res) begin
      Q  <= RST;
      Tc <= 1'b0;
    end else begin
      Q  <= q_nxt;
      Tc <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_tflipflop_bank_counter.sv
// tb/tb_tflipflop_bank_counter.sv - directed checks for tflipflop_bank_counter, full-range and MODULUS=10 instances
module tb_tflipflop_bank_counter;

  logic       Clk = 1'b0;
  logic       Res = 1'b0;
  logic       En = 1'b0;
  logic       Load = 1'b0;
  logic [3:0] Din = 4'h0;
  logic [3:0] T = 4'h0;
  logic [1:0] Mode = 2'b11;
  logic [3:0] q16, q10;
  logic       tc16, tc10;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  tflipflop_bank_counter #(.WIDTH(4)) dut16 (
    .Clk(Clk), .Res(Res), .En(En), .Load(Load), .Din(Din), .T(T), .Mode(Mode),
    .Q(q16), .Tc(tc16)
  );

  tflipflop_bank_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut10 (
    .Clk(Clk), .Res(Res), .En(En), .Load(Load), .Din(Din), .T(T), .Mode(Mode),
    .Q(q10), .Tc(tc10)
  );

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic load_both(input logic [3:0] d);
    Res = 1'b0; Load = 1'b1; Din = d; En = 1'b0;
    step();
    Load = 1'b0;
  endtask

  task automatic test_reset;
    Res = 1'b1; Load = 1'b1; Din = 4'h7; En = 1'b1; Mode = 2'b01;
    step();
    checks++;
    if (q16 !== 4'h0 || tc16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: got q=%h tc=%b want q=0 tc=0", q16, tc16);
    end
    checks++;
    if (q10 !== 4'h0 || tc10 !== 1'b0) begin
      errors++;
      $display("FAIL reset10: got q=%h tc=%b want q=0 tc=0", q10, tc10);
    end
    Res = 1'b0; Load = 1'b1; Din = 4'hF; En = 1'b0;
    step();
    Load = 1'b0;
    checks++;
    if (q16 !== 4'hF || tc16 !== 1'b0) begin
      errors++;
      $display("FAIL load16: got q=%h tc=%b want q=f tc=0", q16, tc16);
    end
    checks++;
    if (q10 !== 4'h9) begin
      errors++;
      $display("FAIL load_clamp10: got q=%h want q=9", q10);
    end
  endtask

  task automatic test_toggle;
    load_both(4'b1010);
    En = 1'b1; Mode = 2'b00; T = 4'b0110;
    step();
    checks++;
    if (q16 !== 4'b1100 || tc16 !== 1'b0) begin
      errors++;
      $display("FAIL toggle: got q=%b tc=%b want q=1100 tc=0", q16, tc16);
    end
    En = 1'b0;
    step();
    checks++;
    if (q16 !== 4'b1100) begin
      errors++;
      $display("FAIL toggle_en0_hold: got q=%b want q=1100", q16);
    end
    En = 1'b1; T = 4'b0000;
    step();
    checks++;
    if (q16 !== 4'b1100 || tc16 !== 1'b0) begin
      errors++;
      $display("FAIL toggle_t0_hold: got q=%b tc=%b want q=1100 tc=0", q16, tc16);
    end
  endtask

  task automatic test_count_up;
    logic [3:0] eq10 [3];
    logic       etc10 [3];
`ifdef TFF_COUNTER_SAT_EN
    eq10 = '{4'd9, 4'd9, 4'd9}; etc10 = '{1'b0, 1'b1, 1'b1};
`else
    eq10 = '{4'd9, 4'd0, 4'd1}; etc10 = '{1'b0, 1'b1, 1'b0};
`endif
    load_both(4'd8);
    En = 1'b1; Mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q10 !== eq10[i] || tc10 !== etc10[i]) begin
        errors++;
        $display("FAIL count_up10[%0d]: got q=%0d tc=%b want q=%0d tc=%b", i, q10, tc10, eq10[i], etc10[i]);
      end
      checks++;
      if (q16 !== 4'(9 + i) || tc16 !== 1'b0) begin
        errors++;
        $display("FAIL count_up16[%0d]: got q=%0d tc=%b want q=%0d tc=0", i, q16, tc16, 9 + i);
      end
    end
  endtask

  task automatic test_count_down;
    logic [3:0] eq10 [2];
    logic [3:0] eq16 [2];
    logic       etc [2];
`ifdef TFF_COUNTER_SAT_EN
    eq10 = '{4'd0, 4'd0}; eq16 = '{4'd0, 4'd0};
`else
    eq10 = '{4'd0, 4'd9}; eq16 = '{4'd0, 4'd15};
`endif
    etc = '{1'b0, 1'b1};
    load_both(4'd12);
    checks++;
    if (q10 !== 4'd9 || q16 !== 4'd12) begin
      errors++;
      $display("FAIL load12: got q10=%0d q16=%0d want q10=9 q16=12", q10, q16);
    end
    load_both(4'd1);
    En = 1'b1; Mode = 2'b10;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q10 !== eq10[i] || tc10 !== etc[i]) begin
        errors++;
        $display("FAIL count_down10[%0d]: got q=%0d tc=%b want q=%0d tc=%b", i, q10, tc10, eq10[i], etc[i]);
      end
      checks++;
      if (q16 !== eq16[i] || tc16 !== etc[i]) begin
        errors++;
        $display("FAIL count_down16[%0d]: got q=%0d tc=%b want q=%0d tc=%b", i, q16, tc16, eq16[i], etc[i]);
      end
    end
  endtask

  task automatic test_reset_on_wrap;
    load_both(4'd9);
    En = 1'b1; Mode = 2'b01; Res = 1'b1; Load = 1'b1; Din = 4'd5;
    step();
    Res = 1'b0; Load = 1'b0;
    checks++;
    if (q10 !== 4'd0 || tc10 !== 1'b0) begin
      errors++;
      $display("FAIL reset_on_wrap: got q=%0d tc=%b want q=0 tc=0", q10, tc10);
    end
  endtask

  task automatic test_mode_change;
    load_both(4'd3);
    En = 1'b1; Mode = 2'b01;
    step();
    checks++;
    if (q10 !== 4'd4) begin
      errors++;
      $display("FAIL mode_up: got q=%0d want q=4", q10);
    end
    Mode = 2'b10;
    step();
    checks++;
    if (q10 !== 4'd3 || tc10 !== 1'b0) begin
      errors++;
      $display("FAIL mode_down: got q=%0d tc=%b want q=3 tc=0", q10, tc10);
    end
    Mode = 2'b11;
    step();
    checks++;
    if (q10 !== 4'd3 || tc10 !== 1'b0) begin
      errors++;
      $display("FAIL mode_hold: got q=%0d tc=%b want q=3 tc=0", q10, tc10);
    end
  endtask

  task automatic test_out_of_range;
    logic [3:0] eup;
`ifdef TFF_COUNTER_SAT_EN
    eup = 4'd9;
`else
    eup = 4'd0;
`endif
    load_both(4'd9);
    En = 1'b1; Mode = 2'b00; T = 4'b0110;
    step();
    checks++;
    if (q10 !== 4'd15) begin
      errors++;
      $display("FAIL oor_toggle: got q=%0d want q=15", q10);
    end
    Mode = 2'b01;
    step();
    checks++;
    if (q10 !== eup || tc10 !== 1'b1) begin
      errors++;
      $display("FAIL oor_up: got q=%0d tc=%b want q=%0d tc=1", q10, tc10, eup);
    end
    load_both(4'd9);
    En = 1'b1; Mode = 2'b00;
    step();
    Mode = 2'b10;
    step();
    checks++;
    if (q10 !== 4'd14 || tc10 !== 1'b0) begin
      errors++;
      $display("FAIL oor_down: got q=%0d tc=%b want q=14 tc=0", q10, tc10);
    end
  endtask

`ifdef TFF_COUNTER_SAT_EN
  task automatic test_saturate;
    load_both(4'd9);
    En = 1'b1; Mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q10 !== 4'd9 || tc10 !== 1'b1) begin
        errors++;
        $display("FAIL sat_up[%0d]: got q=%0d tc=%b want q=9 tc=1", i, q10, tc10);
      end
    end
    Mode = 2'b11;
    step();
    checks++;
    if (q10 !== 4'd9 || tc10 !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold: got q=%0d tc=%b want q=9 tc=0", q10, tc10);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_toggle();
    test_count_up();
    test_count_down();
    test_reset_on_wrap();
    test_mode_change();
    test_out_of_range();
`ifdef TFF_COUNTER_SAT_EN
    test_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
